// File: rtl/cfu_requant_pkg.sv
// Shared definitions for the conv CFU datapath: function codes, FSM states and
// int32 saturation limits.
package cfu_pkg;

  localparam logic [6:0] F7_SET_QPARAMS   = 7'd11;
  localparam logic [6:0] F7_SET_OUTPARAMS = 7'd12;
  localparam logic [6:0] F7_REQUANT       = 7'd13;

  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_P3,
    S_P4,
    S_RESP
  } state_e;

endpackage

// File: rtl/cfu_requant_if.sv
// CFU command/response handshake bundle; master is the CPU side, slave the accelerator.
interface cfu_requant_if #(
  parameter int ACC_W = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [9:0]       cmd_payload_function_id;
  logic [ACC_W-1:0] cmd_payload_inputs_0;
  logic [ACC_W-1:0] cmd_payload_inputs_1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ACC_W-1:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0
  );
endinterface

// File: rtl/cfu_requant_rounding_divide_by_pot.sv
// Arithmetic right shift by rs with round-half-away-from-zero (gemmlowp RDBPOT).
// Purely combinational so the pooling stage can share it.
module rounding_divide_by_pot #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] i_y,
  input  logic        [W-1:0] i_rs,
  output logic signed [W-1:0] o_z
);
  logic        [W-1:0] w_mask;
  logic        [W-1:0] w_rem;
  logic        [W-1:0] w_thr;
  logic signed [W-1:0] w_shr;
  logic                w_up;

  always_comb begin
    w_mask = ({{(W-1){1'b0}}, 1'b1} << i_rs) - {{(W-1){1'b0}}, 1'b1};
    w_rem  = i_y & w_mask;
    // Negative values need a strictly larger remainder to round up, giving
    // symmetric rounding away from zero.
    w_thr  = (w_mask >> 1) + {{(W-1){1'b0}}, i_y[W-1]};
    w_shr  = i_y >>> i_rs;
    w_up   = (w_rem > w_thr);
    o_z    = w_shr + $signed({{(W-1){1'b0}}, w_up});
  end
endmodule

// File: rtl/cfu_requant.sv
// Output requantization: bias add, TFLite fixed-point rescale, offset and
// activation clamp, served over the CFU command/response handshake.
module cfu_requant
  import cfu_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input logic          clk,
  input logic          reset,
  cfu_requant_if.slave cfu
);
  localparam logic signed [ACC_W-1:0]   L_MIN       = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]   L_MAX       = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [2*ACC_W-1:0] L_ONE       = {{(2*ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [2*ACC_W-1:0] L_NUDGE_POS = {{(ACC_W+1){1'b0}}, 1'b1, {(ACC_W-2){1'b0}}};
  localparam logic signed [2*ACC_W-1:0] L_NUDGE_NEG = L_ONE - L_NUDGE_POS;
  localparam logic signed [2*ACC_W-1:0] L_TRUNC     = {{(ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};

  // Saturating rounding doubling high multiply, back half (nudge + high word).
  function automatic logic signed [ACC_W-1:0] srdhm_sat(
    input logic signed [2*ACC_W-1:0] p,
    input logic                      sat
  );
    logic signed [2*ACC_W-1:0] s;
    if (sat) return L_MAX;
    s = p + ((p >= 0) ? L_NUDGE_POS : L_NUDGE_NEG);
    if (s < 0) s = s + L_TRUNC;
    s = s >>> (ACC_W-1);
    return s[ACC_W-1:0];
  endfunction

  // Max against lo first, then min against hi: an inverted range yields hi.
  function automatic logic signed [ACC_W-1:0] clamp_act(
    input logic signed [ACC_W-1:0] v,
    input logic signed [ACC_W-1:0] lo,
    input logic signed [ACC_W-1:0] hi
  );
    logic signed [ACC_W-1:0] t;
    t = (v < lo) ? lo : v;
    t = (t > hi) ? hi : t;
    return t;
  endfunction

  state_e r_state, w_state_nxt;
  logic                      w_accept;
  logic [6:0]                w_func7;
  logic signed [ACC_W-1:0]   r_mult, r_shift, r_out_offset;
  logic signed [OUT_W-1:0]   r_act_min, r_act_max;
  logic [ACC_W-1:0]          r_rsp_data;
  logic signed [ACC_W-1:0]   r_acc, r_bias;
  logic signed [ACC_W-1:0]   r_x_p1;
  logic signed [2*ACC_W-1:0] r_prod_p2;
  logic                      r_sat_p2;
  logic signed [ACC_W-1:0]   r_y_p3;
  logic [ACC_W-1:0]          w_ls, w_rs;
  logic signed [ACC_W-1:0]   w_sum, w_z, w_off, w_out;
  logic signed [2*ACC_W-1:0] w_x_ext, w_mult_ext;

  always_comb begin
    w_state_nxt   = r_state;
    cfu.cmd_ready = (r_state == S_IDLE);
    cfu.rsp_valid = (r_state == S_RESP);
    w_func7       = cfu.cmd_payload_function_id[9:3];
    w_accept      = cfu.cmd_valid && (r_state == S_IDLE);
    case (r_state)
      S_IDLE:  if (cfu.cmd_valid) w_state_nxt = (w_func7 == F7_REQUANT) ? S_P1 : S_RESP;
      S_P1:    w_state_nxt = S_P2;
      S_P2:    w_state_nxt = S_P3;
      S_P3:    w_state_nxt = S_P4;
      S_P4:    w_state_nxt = S_RESP;
      S_RESP:  if (cfu.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cfu.rsp_payload_outputs_0 = r_rsp_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_mult       <= '0;
      r_shift      <= '0;
      r_out_offset <= '0;
      r_act_min    <= '0;
      r_act_max    <= '0;
      r_rsp_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        case (w_func7)
          F7_SET_QPARAMS: begin
            r_mult  <= cfu.cmd_payload_inputs_0;
            r_shift <= cfu.cmd_payload_inputs_1;
          end
          F7_SET_OUTPARAMS: begin
            r_out_offset <= cfu.cmd_payload_inputs_0;
            r_act_min    <= cfu.cmd_payload_inputs_1[OUT_W-1:0];
            r_act_max    <= cfu.cmd_payload_inputs_1[2*OUT_W-1:OUT_W];
          end
          default: ;
        endcase
        r_rsp_data <= '0;
      end else if (r_state == S_P4) begin
        r_rsp_data <= w_out;
      end
    end
  end

  always_comb begin
    w_ls       = (r_shift > 0) ? r_shift : '0;
    w_rs       = (r_shift < 0) ? -r_shift : '0;
    w_sum      = r_acc + r_bias;
    w_x_ext    = {{ACC_W{r_x_p1[ACC_W-1]}}, r_x_p1};
    w_mult_ext = {{ACC_W{r_mult[ACC_W-1]}}, r_mult};
    w_off      = w_z + r_out_offset;
    w_out      = clamp_act(w_off,
                           {{(ACC_W-OUT_W){r_act_min[OUT_W-1]}}, r_act_min},
                           {{(ACC_W-OUT_W){r_act_max[OUT_W-1]}}, r_act_max});
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_acc  <= cfu.cmd_payload_inputs_0;
      r_bias <= cfu.cmd_payload_inputs_1;
    end
    // P1: bias add and left shift
    r_x_p1    <= w_sum << w_ls;
    // P2: full-width product, single DSP multiply
    r_prod_p2 <= w_x_ext * w_mult_ext;
    r_sat_p2  <= (r_x_p1 == L_MIN) && (r_mult == L_MIN);
    // P3: nudge, high word, saturation
    r_y_p3    <= srdhm_sat(r_prod_p2, r_sat_p2);
  end

  // P4: rounding right shift; offset and clamp feed the response register
  rounding_divide_by_pot #(.W(ACC_W)) u_rdbpot (
    .i_y  (r_y_p3),
    .i_rs (w_rs),
    .o_z  (w_z)
  );

endmodule
